// File: rtl/ro_cds_capture.sv
// ro_cds_capture: captures READ_R reset samples into a line buffer and emits S-R CDS pixels via an output FIFO.
// Build macro RO_CDS_CLAMP_EN: when defined, negative S-R results are clamped to zero.
module ro_cds_capture #(
  parameter int ADC_W      = 12,
  parameter int NUM_COL    = 324,
  parameter int COL_W      = 9,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             re_busy,
  input  logic [9:0]       NUM_ROW,
  input  logic [9:0]       ROWADD,
  input  logic             MUX_START,
  input  logic             READ_R,
  input  logic             READ_S,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  output logic [ADC_W:0]   pix_data,
  output logic [9:0]       pix_row,
  output logic [COL_W-1:0] pix_col,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             frame_done,
  output logic             row_err,
  output logic             overflow,
  output logic [2:0]       state_dbg
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 10 + COL_W + ADC_W + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ROW_WAIT = 3'd1,
    SAMP_R   = 3'd2,
    WAIT_S   = 3'd3,
    SAMP_S   = 3'd4
  } state_t;

  state_t           state;
  logic             re_busy_q, read_r_q, read_s_q;
  logic [9:0]       row_q, row_cnt;
  logic [COL_W-1:0] col_cnt, r_cnt;
  logic [ADC_W-1:0] linebuf [NUM_COL];

  logic             s1_valid, s2_valid;
  logic [ADC_W-1:0] s1_s, s1_r;
  logic [COL_W-1:0] s1_col, s2_col;
  logic [9:0]       s1_row, s2_row;
  logic [ADC_W:0]   s2_data, diff, cds_val;

  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] mem_cnt, occ;

  logic busy_fall, both_rd, col_full, lb_we, s_take;
  logic pop, can_push, push, load;

  assign state_dbg = state;

  always_comb begin
    busy_fall = re_busy_q & ~re_busy;
    both_rd   = READ_R & READ_S;
    col_full  = (col_cnt == COL_W'(NUM_COL));
    lb_we     = (state == SAMP_R) & ~busy_fall & ~both_rd & READ_R & adc_valid & ~col_full;
    s_take    = (state == SAMP_S) & ~busy_fall & ~both_rd & READ_S & adc_valid & ~col_full;
  end

  always_comb begin
    diff = {1'b0, s1_s} - {1'b0, s1_r};
`ifdef RO_CDS_CLAMP_EN
    cds_val = diff[ADC_W] ? '0 : diff;
`else
    cds_val = diff;
`endif
  end

  // Occupancy counts the output register, so FIFO_DEPTH pixels can be held in total.
  always_comb begin
    occ      = mem_cnt + {{PTR_W{1'b0}}, pix_valid};
    pop      = pix_valid & pix_ready;
    can_push = (occ < CNT_W'(FIFO_DEPTH)) | pop;
    push     = s2_valid & can_push;
    load     = (~pix_valid | pix_ready) & (mem_cnt != '0);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      re_busy_q  <= 1'b0;
      read_r_q   <= 1'b0;
      read_s_q   <= 1'b0;
      row_q      <= '0;
      row_cnt    <= '0;
      col_cnt    <= '0;
      r_cnt      <= '0;
      frame_done <= 1'b0;
      row_err    <= 1'b0;
    end else begin
      re_busy_q  <= re_busy;
      read_r_q   <= READ_R;
      read_s_q   <= READ_S;
      frame_done <= 1'b0;
      if (busy_fall) begin
        state      <= IDLE;
        frame_done <= 1'b1;
        row_cnt    <= '0;
        if (row_cnt != NUM_ROW) row_err <= 1'b1;
      end else begin
        case (state)
          IDLE: if (re_busy & ~re_busy_q) state <= ROW_WAIT;
          ROW_WAIT: begin
            if (READ_S) row_err <= 1'b1;
            if (MUX_START) begin
              row_q   <= ROWADD;
              col_cnt <= '0;
              state   <= SAMP_R;
            end
          end
          SAMP_R: begin
            if (both_rd) begin
              row_err <= 1'b1;
              state   <= ROW_WAIT;
            end else if (read_r_q & ~READ_R) begin
              r_cnt <= col_cnt;
              state <= WAIT_S;
            end else if (READ_R & adc_valid) begin
              if (col_full) row_err <= 1'b1;
              else          col_cnt <= col_cnt + COL_W'(1);
            end
          end
          WAIT_S: begin
            if (both_rd) begin
              row_err <= 1'b1;
              state   <= ROW_WAIT;
            end else if (READ_S & ~read_s_q) begin
              col_cnt <= '0;
              state   <= SAMP_S;
            end
          end
          SAMP_S: begin
            if (both_rd) begin
              row_err <= 1'b1;
              state   <= ROW_WAIT;
            end else if (read_s_q & ~READ_S) begin
              row_cnt <= row_cnt + 10'd1;
              if (col_cnt != r_cnt) row_err <= 1'b1;
              state <= ROW_WAIT;
            end else if (READ_S & adc_valid) begin
              if (col_full) row_err <= 1'b1;
              else          col_cnt <= col_cnt + COL_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (lb_we) linebuf[col_cnt] <= adc_data;
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= {s2_row, s2_col, s2_data};
  end

  // Stage 1 reads the stored reset sample, stage 2 registers S-R, then FIFO, then output register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_s      <= '0;
      s1_r      <= '0;
      s1_col    <= '0;
      s1_row    <= '0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_col    <= '0;
      s2_row    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_row   <= '0;
      pix_col   <= '0;
      overflow  <= 1'b0;
    end else begin
      s1_valid <= s_take;
      if (s_take) begin
        s1_s   <= adc_data;
        s1_r   <= linebuf[col_cnt];
        s1_col <= col_cnt;
        s1_row <= row_q;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= cds_val;
        s2_col  <= s1_col;
        s2_row  <= s1_row;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (s2_valid & ~can_push) overflow <= 1'b1;
      if (load) begin
        {pix_row, pix_col, pix_data} <= fifo_mem[rd_ptr];
        rd_ptr    <= rd_ptr + PTR_W'(1);
        pix_valid <= 1'b1;
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end
      if (push & ~load)      mem_cnt <= mem_cnt + CNT_W'(1);
      else if (~push & load) mem_cnt <= mem_cnt - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ro_cds_capture.sv
// Directed self-checking bench for ro_cds_capture: row capture, latency, frames, clamp, overflow, error and reset cases.
`timescale 1ns/1ps
module tb_ro_cds_capture;
  localparam int ADC_W = 12;
  localparam int NUM_COL = 324;
  localparam int COL_W = 9;
  localparam int FIFO_DEPTH = 16;
  localparam int E_W = 10 + COL_W + ADC_W + 1;

  logic             CLK = 1'b0;
  logic             rst, re_busy, MUX_START, READ_R, READ_S, adc_valid, pix_ready;
  logic [9:0]       NUM_ROW, ROWADD;
  logic [ADC_W-1:0] adc_data;
  logic [ADC_W:0]   pix_data;
  logic [9:0]       pix_row;
  logic [COL_W-1:0] pix_col;
  logic             pix_valid, frame_done, row_err, overflow;
  logic [2:0]       state_dbg;

  ro_cds_capture #(.ADC_W(ADC_W), .NUM_COL(NUM_COL), .COL_W(COL_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK(CLK), .rst(rst), .re_busy(re_busy), .NUM_ROW(NUM_ROW), .ROWADD(ROWADD),
    .MUX_START(MUX_START), .READ_R(READ_R), .READ_S(READ_S), .adc_data(adc_data),
    .adc_valid(adc_valid), .pix_data(pix_data), .pix_row(pix_row), .pix_col(pix_col),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_done(frame_done),
    .row_err(row_err), .overflow(overflow), .state_dbg(state_dbg)
  );

  // ---- clock / reset ----
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int frame_cnt = 0;
  int pv_rise_cyc = 0;
  int s_start_cyc = 0;
  logic pv_q = 1'b0;
  logic [E_W-1:0] exp_q[$];
  logic [E_W-1:0] got_q[$];
  int r_arr[NUM_COL];
  int s_arr[NUM_COL];

  always @(posedge CLK) cyc++;

  // Pixel collector: records every accepted pixel away from the active edge.
  always @(negedge CLK) begin
    if (pix_valid && pix_ready) got_q.push_back({pix_row, pix_col, pix_data});
    if (frame_done) frame_cnt++;
    if (pix_valid && !pv_q) pv_rise_cyc = cyc;
    pv_q = pix_valid;
  end

  // ---- driver tasks ----
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; re_busy = 1'b0; MUX_START = 1'b0; READ_R = 1'b0; READ_S = 1'b0;
    adc_valid = 1'b0; adc_data = '0; ROWADD = '0;
    #100;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic start_frame(input int nrow);
    NUM_ROW = 10'(nrow);
    re_busy = 1'b1;
    tick;
    tick;
  endtask

  task automatic end_frame;
    re_busy = 1'b0;
    tick;
  endtask

  task automatic run_row(input int row, input int nr, input int ns);
    tick; ROWADD = 10'(row); MUX_START = 1'b1;
    tick; MUX_START = 1'b0;
    tick; READ_R = 1'b1;
    tick;
    for (int i = 0; i < nr; i++) begin
      adc_valid = 1'b1; adc_data = 12'(r_arr[i]); tick;
    end
    adc_valid = 1'b0; READ_R = 1'b0;
    tick; tick; READ_S = 1'b1;
    tick;
    for (int i = 0; i < ns; i++) begin
      if (i == 0) s_start_cyc = cyc;
      adc_valid = 1'b1; adc_data = 12'(s_arr[i]); tick;
    end
    adc_valid = 1'b0; READ_S = 1'b0;
    tick; tick;
  endtask

  // ---- tests ----
  task automatic test_reset;
    do_reset;
    n_cmp++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid got %0b want 0", pix_valid); end
    n_cmp++; if (pix_data !== '0) begin n_fail++; $display("FAIL reset_pix_data got %0h want 0", pix_data); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %0b want 0", frame_done); end
    n_cmp++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL reset_row_err got %0b want 0", row_err); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    n_cmp++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_dbg); end
  endtask

  task automatic test_basic_row;
    logic [E_W-1:0] g;
    int fc0;
    do_reset;
    pix_ready = 1'b1;
    got_q.delete(); exp_q.delete();
    r_arr[0] = 100; r_arr[1] = 200; r_arr[2] = 300;
    s_arr[0] = 400; s_arr[1] = 250; s_arr[2] = 300;
    exp_q.push_back({10'd5, 9'd0, 13'd300});
    exp_q.push_back({10'd5, 9'd1, 13'd50});
    exp_q.push_back({10'd5, 9'd2, 13'd0});
    start_frame(1);
    run_row(5, 3, 3);
    repeat (8) tick;
    n_cmp++; if (pv_rise_cyc - s_start_cyc !== 4) begin n_fail++; $display("FAIL basic_latency got %0d want 4", pv_rise_cyc - s_start_cyc); end
    fc0 = frame_cnt;
    end_frame;
    n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL basic_frame_done got %0b want 1", frame_done); end
    tick;
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_frame_done_pulse got %0b want 0", frame_done); end
    n_cmp++; if (frame_cnt - fc0 !== 1) begin n_fail++; $display("FAIL basic_frame_cnt got %0d want 1", frame_cnt - fc0); end
    n_cmp++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL basic_row_err got %0b want 0", row_err); end
    n_cmp++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL basic_count got %0d want 3", got_q.size()); end
    while (exp_q.size() > 0) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : '1;
      n_cmp++; if (g !== exp_q[0]) begin n_fail++; $display("FAIL basic_pixel got %08h want %08h", g, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_clamp;
    logic [E_W-1:0] g;
    got_q.delete(); exp_q.delete();
    r_arr[0] = 500;  s_arr[0] = 100;
    r_arr[1] = 100;  s_arr[1] = 4095;
`ifdef RO_CDS_CLAMP_EN
    exp_q.push_back({10'd7, 9'd0, 13'h0000});
`else
    exp_q.push_back({10'd7, 9'd0, 13'h1E70});
`endif
    exp_q.push_back({10'd7, 9'd1, 13'd3995});
    start_frame(1);
    run_row(7, 2, 2);
    repeat (8) tick;
    end_frame;
    n_cmp++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL clamp_count got %0d want 2", got_q.size()); end
    while (exp_q.size() > 0) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : '1;
      n_cmp++; if (g !== exp_q[0]) begin n_fail++; $display("FAIL clamp_pixel got %08h want %08h", g, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back;
    logic [E_W-1:0] g;
    int fc0;
    do_reset;
    pix_ready = 1'b1;
    got_q.delete(); exp_q.delete();
    start_frame(20);
    for (int row = 0; row < 20; row++) begin
      for (int c = 0; c < NUM_COL; c++) begin
        r_arr[c] = row * 16 + c;
        s_arr[c] = row * 16 + c + c;
        exp_q.push_back({10'(row), 9'(c), 13'(c)});
      end
      run_row(row, NUM_COL, NUM_COL);
    end
    repeat (10) tick;
    fc0 = frame_cnt;
    end_frame;
    n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_done got %0b want 1", frame_done); end
    tick;
    n_cmp++; if (frame_cnt - fc0 !== 1) begin n_fail++; $display("FAIL frame_cnt got %0d want 1", frame_cnt - fc0); end
    n_cmp++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL frame_row_err got %0b want 0", row_err); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL frame_overflow got %0b want 0", overflow); end
    n_cmp++; if (got_q.size() !== 6480) begin n_fail++; $display("FAIL frame_count got %0d want 6480", got_q.size()); end
    while (exp_q.size() > 0) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : '1;
      n_cmp++; if (g !== exp_q[0]) begin n_fail++; $display("FAIL frame_pixel got %08h want %08h", g, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_overflow;
    logic [E_W-1:0] g;
    pix_ready = 1'b0;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      r_arr[i] = i * 10;
      s_arr[i] = i * 11;
    end
    for (int i = 0; i < FIFO_DEPTH; i++) exp_q.push_back({10'd3, 9'(i), 13'(i)});
    start_frame(1);
    run_row(3, 20, 20);
    repeat (6) tick;
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    n_cmp++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_held_valid got %0b want 1", pix_valid); end
    n_cmp++; if ({pix_col, pix_data} !== {9'd0, 13'd0}) begin n_fail++; $display("FAIL ovf_held_head got col %0d data %0d want col 0 data 0", pix_col, pix_data); end
    n_cmp++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL ovf_no_pop got %0d want 0", got_q.size()); end
    n_cmp++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL ovf_row_err got %0b want 0", row_err); end
    pix_ready = 1'b1;
    repeat (30) tick;
    end_frame;
    n_cmp++; if (got_q.size() !== FIFO_DEPTH) begin n_fail++; $display("FAIL ovf_count got %0d want %0d", got_q.size(), FIFO_DEPTH); end
    while (exp_q.size() > 0) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : '1;
      n_cmp++; if (g !== exp_q[0]) begin n_fail++; $display("FAIL ovf_pixel got %08h want %08h", g, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    tick;
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
  endtask

  task automatic test_row_err;
    do_reset;
    pix_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r_arr[i] = 50 + i;
      s_arr[i] = 60 + i;
    end
    start_frame(1);
    n_cmp++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL err_pre got %0b want 0", row_err); end
    run_row(2, 3, 4);
    n_cmp++; if (row_err !== 1'b1) begin n_fail++; $display("FAIL err_count got %0b want 1", row_err); end
    end_frame;
    // READ_R and READ_S together during reset sampling
    do_reset;
    start_frame(1);
    ROWADD = 10'd1; MUX_START = 1'b1;
    tick; MUX_START = 1'b0; READ_R = 1'b1;
    tick; tick;
    n_cmp++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL err_overlap_pre got %0b want 0", row_err); end
    READ_S = 1'b1;
    tick;
    n_cmp++; if (row_err !== 1'b1) begin n_fail++; $display("FAIL err_overlap got %0b want 1", row_err); end
    n_cmp++; if (state_dbg !== 3'd1) begin n_fail++; $display("FAIL err_overlap_state got %0d want 1", state_dbg); end
    READ_R = 1'b0; READ_S = 1'b0;
    tick;
    end_frame;
    // READ_S with no row in progress
    do_reset;
    start_frame(1);
    READ_S = 1'b1;
    tick;
    READ_S = 1'b0;
    n_cmp++; if (row_err !== 1'b1) begin n_fail++; $display("FAIL err_read_s_idle got %0b want 1", row_err); end
    end_frame;
    got_q.delete();
  endtask

  task automatic test_reset_mid_row;
    logic [E_W-1:0] g;
    do_reset;
    pix_ready = 1'b0;
    got_q.delete(); exp_q.delete();
    start_frame(20);
    tick; ROWADD = 10'd9; MUX_START = 1'b1;
    tick; MUX_START = 1'b0;
    tick; READ_R = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin adc_valid = 1'b1; adc_data = 12'(10 + i); tick; end
    adc_valid = 1'b0; READ_R = 1'b0;
    tick; tick; READ_S = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin adc_valid = 1'b1; adc_data = 12'(90 + i); tick; end
    adc_valid = 1'b0;
    repeat (5) tick;
    n_cmp++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %0b want 1", pix_valid); end
    n_cmp++; if (state_dbg !== 3'd4) begin n_fail++; $display("FAIL mid_pre_state got %0d want 4", state_dbg); end
    rst = 1'b1; re_busy = 1'b0; READ_S = 1'b0;
    tick;
    n_cmp++; if ({pix_valid, frame_done, row_err, overflow} !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_flags got %4b want 0000", {pix_valid, frame_done, row_err, overflow}); end
    n_cmp++; if ({pix_row, pix_col, pix_data} !== '0) begin n_fail++; $display("FAIL mid_rst_pix got %08h want 0", {pix_row, pix_col, pix_data}); end
    n_cmp++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL mid_rst_state got %0d want 0", state_dbg); end
    rst = 1'b0;
    tick;
    got_q.delete();
    pix_ready = 1'b1;
    start_frame(20);
    for (int row = 0; row < 19; row++) begin
      for (int c = 0; c < 4; c++) begin
        r_arr[c] = 10 * c;
        s_arr[c] = 10 * c + row + c;
        exp_q.push_back({10'(row), 9'(c), 13'(row + c)});
      end
      run_row(row, 4, 4);
    end
    repeat (10) tick;
    n_cmp++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL short_pre_err got %0b want 0", row_err); end
    end_frame;
    n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL short_frame_done got %0b want 1", frame_done); end
    n_cmp++; if (row_err !== 1'b1) begin n_fail++; $display("FAIL short_row_err got %0b want 1", row_err); end
    n_cmp++; if (got_q.size() !== 76) begin n_fail++; $display("FAIL short_count got %0d want 76", got_q.size()); end
    while (exp_q.size() > 0) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : '1;
      n_cmp++; if (g !== exp_q[0]) begin n_fail++; $display("FAIL short_pixel got %08h want %08h", g, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    pix_ready = 1'b1;
    NUM_ROW = '0;
    test_reset;
    test_basic_row;
    test_clamp;
    test_back_to_back;
    test_overflow;
    test_row_err;
    test_reset_mid_row;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
